pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It merges stall requests from ID, EX and MEM into the 6-bit stall vector consumed by every inter-stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences exception flushes: it detects a committed exception from MEM, drives a registered multi-cycle flush, and supplies the redirect PC. An optional watchdog flags pipelines that stay stalled too long.

---
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests and sequences exception flushes.
// Optional stall watchdog is built when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] INT_VEC      = 32'h0000_0020,
    parameter logic [31:0] EXC_VEC      = 32'h0000_0040,
    parameter logic [15:0] STALL_MAX    = 16'd1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stallreq_id,
    input  logic        i_stallreq_ex,
    input  logic        i_stallreq_mem,
    input  logic [31:0] i_except_type,
    input  logic [31:0] i_cp0_epc,
    output logic [5:0]  o_stall,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic        o_new_pc_vld,
    output logic        o_stall_timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  flush_cnt;
    logic [3:0]  flush_cnt_nxt;
    logic [31:0] new_pc_nxt;
    logic        new_pc_vld_nxt;
    logic [31:0] redirect_pc;
    logic [5:0]  stall_req;
    logic        except_hit;

    assign except_hit = (i_except_type != 32'd0);

    always_comb begin
        redirect_pc = EXC_VEC;
        case (i_except_type)
            32'h0000_0001: redirect_pc = INT_VEC;
            32'h0000_0008,
            32'h0000_0009,
            32'h0000_000a,
            32'h0000_000c,
            32'h0000_000d: redirect_pc = EXC_VEC;
            32'h0000_000e: redirect_pc = i_cp0_epc;
            default:       redirect_pc = EXC_VEC;
        endcase
    end

    // Deeper stages freeze everything upstream of them; exceptions and flushes override stalls.
    always_comb begin
        stall_req = 6'b000000;
        if (i_stallreq_mem) begin
            stall_req = 6'b011111;
        end else if (i_stallreq_ex) begin
            stall_req = 6'b001111;
        end else if (i_stallreq_id) begin
            stall_req = 6'b000111;
        end
        o_stall = stall_req;
        if (i_rst || (state == FLUSH) || except_hit) begin
            o_stall = 6'b000000;
        end
    end

    always_comb begin
        state_nxt      = state;
        flush_cnt_nxt  = flush_cnt;
        new_pc_nxt     = o_new_pc;
        new_pc_vld_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (except_hit) begin
                    state_nxt      = FLUSH;
                    flush_cnt_nxt  = FLUSH_INIT;
                    new_pc_nxt     = redirect_pc;
                    new_pc_vld_nxt = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            flush_cnt    <= 4'd0;
            o_flush      <= 1'b0;
            o_new_pc     <= 32'd0;
            o_new_pc_vld <= 1'b0;
        end else begin
            state        <= state_nxt;
            flush_cnt    <= flush_cnt_nxt;
            o_flush      <= (state_nxt == FLUSH);
            o_new_pc     <= new_pc_nxt;
            o_new_pc_vld <= new_pc_vld_nxt;
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    logic [15:0] wdog_cnt;

    // Counts consecutive stalled cycles; the flag latches one edge after the threshold is reached.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wdog_cnt        <= 16'd0;
            o_stall_timeout <= 1'b0;
        end else begin
            if (o_stall != 6'b000000) begin
                if (wdog_cnt < STALL_MAX) begin
                    wdog_cnt <= wdog_cnt + 16'd1;
                end
            end else begin
                wdog_cnt <= 16'd0;
            end
            if (wdog_cnt == STALL_MAX) begin
                o_stall_timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_stall_max;
    assign unused_stall_max = ^STALL_MAX;
    assign o_stall_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    localparam int          FC   = 3;
    localparam int          SMAX = 8;
    localparam logic [31:0] IVEC = 32'h0000_0020;
    localparam logic [31:0] EVEC = 32'h0000_0040;

    logic        clk;
    logic        rst;
    logic        sid;
    logic        sex;
    logic        smem;
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        new_pc_vld;
    logic        timeout;

    pipe_ctrl #(
        .FLUSH_CYCLES(FC),
        .INT_VEC(IVEC),
        .EXC_VEC(EVEC),
        .STALL_MAX(16'(SMAX))
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_stallreq_id(sid),
        .i_stallreq_ex(sex),
        .i_stallreq_mem(smem),
        .i_except_type(exc),
        .i_cp0_epc(epc),
        .o_stall(stall),
        .o_flush(flush),
        .o_new_pc(new_pc),
        .o_new_pc_vld(new_pc_vld),
        .o_stall_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        vld;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    int   cycle       = 0;

    // Reference model state: remaining flush cycles, pending strobe, redirect, watchdog.
    int          m_flush_left = 0;
    logic        m_strobe     = 1'b0;
    logic [31:0] m_pc         = 32'd0;
    int          m_wd         = 0;
    logic        m_to         = 1'b0;

    function automatic logic [5:0] model_stall(input logic r, input logic i, input logic e,
                                              input logic m, input logic [31:0] x, input int fl);
        if (r || fl > 0 || x != 0) return 6'd0;
        if (m) return 6'b011111;
        if (e) return 6'b001111;
        if (i) return 6'b000111;
        return 6'd0;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] x, input logic [31:0] p);
        if (x == 32'h1) return IVEC;
        if (x == 32'he) return p;
        return EVEC;
    endfunction

    // Applies the clock edge that ends the cycle whose inputs are currently driven.
    task automatic model_advance();
        logic [5:0] old_stall;
        old_stall = model_stall(rst, sid, sex, smem, exc, m_flush_left);
        if (rst) begin
            m_flush_left = 0;
            m_strobe     = 1'b0;
            m_pc         = 32'd0;
            m_wd         = 0;
            m_to         = 1'b0;
        end else begin
`ifdef PIPE_CTRL_WDOG_EN
            if (m_wd == SMAX) m_to = 1'b1;
            if (old_stall != 0) m_wd = (m_wd < SMAX) ? m_wd + 1 : m_wd;
            else m_wd = 0;
`endif
            if (m_flush_left > 0) begin
                m_flush_left = m_flush_left - 1;
                m_strobe     = 1'b0;
            end else if (exc != 0) begin
                m_flush_left = FC;
                m_strobe     = 1'b1;
                m_pc         = model_target(exc, epc);
            end else begin
                m_strobe = 1'b0;
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic i, input logic e, input logic m,
                                  input logic [31:0] x, input logic [31:0] p);
        exp_t ex;
        @(posedge clk);
        #1;
        model_advance();
        cycle = cycle + 1;
        rst  = r;
        sid  = i;
        sex  = e;
        smem = m;
        exc  = x;
        epc  = p;
        ex.cyc   = cycle;
        ex.stall = model_stall(r, i, e, m, x, m_flush_left);
        ex.flush = (m_flush_left > 0);
        ex.pc    = m_pc;
        ex.vld   = m_strobe;
        ex.to    = m_to;
        exp_q.push_back(ex);
    endtask

    task automatic check_output(input exp_t ex);
        check_count = check_count + 1;
        if (stall === ex.stall && flush === ex.flush && new_pc === ex.pc &&
            new_pc_vld === ex.vld && timeout === ex.to) begin
            pass_count = pass_count + 1;
        end else begin
            $display("[TB] FAIL outputs cycle %0d: got stall=%b flush=%b vld=%b pc=%h to=%b, expected stall=%b flush=%b vld=%b pc=%h to=%b",
                     ex.cyc, stall, flush, new_pc_vld, new_pc, timeout,
                     ex.stall, ex.flush, ex.vld, ex.pc, ex.to);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check_output(exp_q.pop_front());
        end
    end

    function automatic logic [31:0] pick_exc();
        case ($urandom_range(0, 7))
            0:       return 32'h1;
            1:       return 32'h8;
            2:       return 32'h9;
            3:       return 32'ha;
            4:       return 32'hd;
            5:       return 32'hc;
            6:       return 32'he;
            default: return $urandom | 32'h100;
        endcase
    endfunction

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        sid  = 1'b0;
        sex  = 1'b0;
        smem = 1'b0;
        exc  = 32'd0;
        epc  = 32'd0;

        for (int k = 0; k < 2; k++)
            apply_stimulus(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
        idle_cycles(1);

        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0);
        idle_cycles(1);

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'hc, 32'd0);
        idle_cycles(5);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'd0);
        idle_cycles(5);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'h1000_0104);
        idle_cycles(5);

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h9, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        idle_cycles(2);

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'hd, 32'd0);
        idle_cycles(1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle_cycles(5);

        for (int k = 0; k < 10; k++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        idle_cycles(3);

        for (int k = 0; k < 400; k++) begin
            apply_stimulus(($urandom_range(0, 59) == 0),
                           ($urandom_range(0, 2) == 0),
                           ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 5) == 0),
                           ($urandom_range(0, 7) == 0) ? pick_exc() : 32'd0,
                           $urandom);
        end
        idle_cycles(2);

        @(negedge clk);
        @(negedge clk);
        check_count = check_count + 1;
        if (exp_q.size() == 0) begin
            pass_count = pass_count + 1;
        end else begin
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
